i2c_master_arbiter: RTL and testbench

Sequencer and two-port round-robin arbiter in front of the I2C `master` block. It accepts complete transaction requests (slave address, write data, direction) from two independent requesters. It grants the single bus master to one requester at a time and drives the master's `slave_add`/`data`/`r_w`/`start_cond` inputs. It watches the master's busy/nack status and returns a completion pulse, error flag and read data to the owning requester.

---
 rtl/i2c_master_arbiter.sv | 166 ++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter
// Two-port round-robin arbiter and sequencer in front of the I2C master block.
// Each requester supplies a complete transaction (address, write byte, direction)
// and holds req high. The winner's fields are latched and driven to the master,
// a start pulse is issued, and the master's busy/nack status is tracked. A
// one-cycle ack (with error flag and read data) is then returned to the owner.
//
// Ports:
//   clock, reset           - rising-edge clock, asynchronous active-low reset
//   req*/add*/wdata*/rw*   - per-requester level request and transaction fields
//   ack*/err*              - per-requester completion pulse and error flag
//   rdata                  - shared read byte, valid during any ack pulse
//   grant                  - one-hot current owner, 2'b00 when idle
//   m_slave_add/m_data/m_r_w/m_start_cond - registered drive to the master
//   m_busy/m_nack/m_rdata  - master status, sampled when busy falls
module i2c_master_arbiter #(
    parameter int unsigned START_CYCLES = 5,
    parameter int unsigned TIMEOUT      = 4095
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [6:0] add0,
    input  logic [6:0] add1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic       rw0,
    input  logic       rw1,
    output logic       ack0,
    output logic       ack1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] rdata,
    output logic [1:0] grant,
    output logic [6:0] m_slave_add,
    output logic [7:0] m_data,
    output logic       m_r_w,
    output logic       m_start_cond,
    input  logic       m_busy,
    input  logic       m_nack,
    input  logic [7:0] m_rdata
);

    localparam int unsigned StartW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [StartW-1:0] StartLast = StartW'(START_CYCLES - 1);
    localparam logic [11:0] TmoLast = 12'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StStart,
        StWaitBusy,
        StWaitDone,
        StResp
    } state_e;

    state_e            state_q;
    logic              owner_q;   // 0 = requester 0, 1 = requester 1
    logic              last_q;    // requester served most recently
    logic [StartW-1:0] start_cnt_q;
    logic [11:0]       tmo_cnt_q;

    logic       winner;
    logic       tmo_hit;
    logic       fin;
    logic       fin_err;
    logic [7:0] fin_rdata;

    // On a tie the requester not served last wins.
    assign winner  = (req0 && req1) ? ~last_q : req1;
    // The counter reaches TIMEOUT on the edge where it currently holds TIMEOUT-1.
    assign tmo_hit = (tmo_cnt_q == TmoLast);

    // Completion detection; busy falling takes priority over a coincident timeout.
    always_comb begin
        fin       = 1'b0;
        fin_err   = 1'b1;
        fin_rdata = 8'h00;
        if (state_q == StWaitDone && !m_busy) begin
            fin       = 1'b1;
            fin_err   = m_nack;
            fin_rdata = m_r_w ? m_rdata : 8'h00;
        end else if ((state_q == StWaitBusy || state_q == StWaitDone) && tmo_hit) begin
            fin = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            start_cnt_q  <= '0;
            tmo_cnt_q    <= '0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            rdata        <= 8'h00;
            grant        <= 2'b00;
            m_slave_add  <= 7'h00;
            m_data       <= 8'h00;
            m_r_w        <= 1'b0;
            m_start_cond <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        owner_q <= winner;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    m_slave_add  <= owner_q ? add1 : add0;
                    m_data       <= owner_q ? wdata1 : wdata0;
                    m_r_w        <= owner_q ? rw1 : rw0;
                    grant        <= owner_q ? 2'b10 : 2'b01;
                    last_q       <= owner_q;
                    m_start_cond <= 1'b1;
                    start_cnt_q  <= '0;
                    state_q      <= StStart;
                end
                StStart: begin
                    if (start_cnt_q == StartLast) begin
                        m_start_cond <= 1'b0;
                        tmo_cnt_q    <= '0;
                        state_q      <= StWaitBusy;
                    end else begin
                        start_cnt_q <= start_cnt_q + StartW'(1);
                    end
                end
                StWaitBusy, StWaitDone: begin
                    if (fin) begin
                        state_q <= StResp;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 12'd1;
                        if (state_q == StWaitBusy && m_busy) begin
                            state_q <= StWaitDone;
                        end
                    end
                end
                StResp: begin
                    grant   <= 2'b00;
                    rdata   <= 8'h00;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // Ack/err are raised on entry to RESP so they are high for exactly that cycle.
            if (fin) begin
                ack0  <= ~owner_q;
                ack1  <= owner_q;
                err0  <= ~owner_q & fin_err;
                err1  <= owner_q & fin_err;
                rdata <= fin_rdata;
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
module tb_i2c_master_arbiter;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [6:0] add0, add1;
    logic [7:0] wdata0, wdata1;
    logic       rw0, rw1;
    logic       m_busy, m_nack;
    logic [7:0] m_rdata;

    logic       ack0, ack1, err0, err1, m_r_w, m_start_cond;
    logic [7:0] rdata, m_data;
    logic [1:0] grant;
    logic [6:0] m_slave_add;

    logic       t_ack0, t_ack1, t_err0, t_err1, t_r_w, t_start;
    logic [7:0] t_rdata, t_data;
    logic [1:0] t_grant;
    logic [6:0] t_slave_add;

    int n_tests = 0;
    int n_fail  = 0;
    int ack1_cnt = 0;

    always #5 clock = ~clock;

    i2c_master_arbiter #(.START_CYCLES(5), .TIMEOUT(100)) dut (
        .clock(clock), .reset(rst_n),
        .req0(req0), .req1(req1), .add0(add0), .add1(add1),
        .wdata0(wdata0), .wdata1(wdata1), .rw0(rw0), .rw1(rw1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .grant(grant),
        .m_slave_add(m_slave_add), .m_data(m_data), .m_r_w(m_r_w),
        .m_start_cond(m_start_cond),
        .m_busy(m_busy), .m_nack(m_nack), .m_rdata(m_rdata)
    );

    // Short-timeout copy sharing all inputs.
    i2c_master_arbiter #(.START_CYCLES(5), .TIMEOUT(20)) dut_to (
        .clock(clock), .reset(rst_n),
        .req0(req0), .req1(req1), .add0(add0), .add1(add1),
        .wdata0(wdata0), .wdata1(wdata1), .rw0(rw0), .rw1(rw1),
        .ack0(t_ack0), .ack1(t_ack1), .err0(t_err0), .err1(t_err1),
        .rdata(t_rdata), .grant(t_grant),
        .m_slave_add(t_slave_add), .m_data(t_data), .m_r_w(t_r_w),
        .m_start_cond(t_start),
        .m_busy(m_busy), .m_nack(m_nack), .m_rdata(m_rdata)
    );

    always @(negedge clock) if (ack1) ack1_cnt <= ack1_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; m_busy = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Returns on the first negedge after the selected start pulse falls.
    task automatic wait_start(input bit which);
        int n = 0;
        while (((which ? t_start : m_start_cond) == 1'b0) && n < 100) begin
            tick(1);
            n++;
        end
        while (((which ? t_start : m_start_cond) == 1'b1) && n < 100) begin
            tick(1);
            n++;
        end
        check("start_wait_bound", 32'(n < 100), 32'd1);
    endtask

    // Master model: busy rises dly cycles after start falls, held for hold cycles.
    // Returns at the negedge where the ack is visible.
    task automatic serve(input bit which, input int dly, input int hold,
                         input logic nack, input logic [7:0] rd);
        wait_start(which);
        tick(dly);
        m_busy = 1'b1;
        tick(hold);
        m_busy = 1'b0; m_nack = nack; m_rdata = rd;
        tick(1);
        m_nack = 1'b0; m_rdata = 8'h00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int a1;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; add0 = '0; add1 = '0; wdata0 = '0; wdata1 = '0;
        rw0 = 1'b0; rw1 = 1'b0; m_busy = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        tick(2);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_start", 32'(m_start_cond), 32'd0);
        check("rst_acks", 32'({ack0, ack1, err0, err1}), 32'd0);
        check("rst_fields", 32'({m_slave_add, m_data, m_r_w, rdata}), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Single write with precise timing.
        req0 = 1'b1; add0 = 7'b1110101; wdata0 = 8'h29; rw0 = 1'b0;
        tick(1);
        check("w_start_lat1", 32'(m_start_cond), 32'd0);
        tick(1);
        check("w_start_lat2", 32'(m_start_cond), 32'd1);
        check("w_add", 32'(m_slave_add), 32'h75);
        check("w_data", 32'(m_data), 32'h29);
        check("w_grant", 32'(grant), 32'b01);
        cnt = 0;
        while (m_start_cond && cnt < 20) begin
            tick(1);
            cnt++;
        end
        check("w_start_len", 32'(cnt), 32'd5);
        tick(2);
        m_busy = 1'b1;
        tick(40);
        check("w_no_early_ack", 32'(ack0), 32'd0);
        m_busy = 1'b0; m_rdata = 8'h5A;
        tick(1);
        m_rdata = 8'h00;
        check("w_ack0", 32'(ack0), 32'd1);
        check("w_err0", 32'(err0), 32'd0);
        check("w_rdata_forced0", 32'(rdata), 32'd0);
        req0 = 1'b0;
        tick(1);
        check("w_ack0_pulse", 32'(ack0), 32'd0);
        check("w_grant_idle", 32'(grant), 32'd0);
        check("w_no_ack1", 32'(ack1_cnt), 32'd0);

        // Contention: alternate starting with requester 0.
        do_reset();
        req0 = 1'b1; add0 = 7'h11; wdata0 = 8'h01; rw0 = 1'b0;
        req1 = 1'b1; add1 = 7'h22; wdata1 = 8'h02; rw1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            serve(1'b0, 1, 3, 1'b0, 8'h00);
            check($sformatf("c_grant%0d", k), 32'(grant), (k % 2 == 0) ? 32'b01 : 32'b10);
            check($sformatf("c_acks%0d", k), 32'({ack1, ack0}), (k % 2 == 0) ? 32'b01 : 32'b10);
            check($sformatf("c_add%0d", k), 32'(m_slave_add), (k % 2 == 0) ? 32'h11 : 32'h22);
            if (k == 2) req0 = 1'b0;
            if (k == 3) req1 = 1'b0;
        end

        // Read with NACK on requester 1.
        tick(2);
        req1 = 1'b1; add1 = 7'h3C; wdata1 = 8'h00; rw1 = 1'b1;
        serve(1'b0, 2, 5, 1'b1, 8'hA5);
        check("r_ack1", 32'(ack1), 32'd1);
        check("r_err1", 32'(err1), 32'd1);
        check("r_rdata", 32'(rdata), 32'hA5);
        check("r_ack0_err0", 32'({ack0, err0}), 32'd0);
        check("r_rw", 32'(m_r_w), 32'd1);
        req1 = 1'b0; rw1 = 1'b0;

        // Timeout on the TIMEOUT=20 instance: busy never asserts.
        do_reset();
        req0 = 1'b1; add0 = 7'h2A; wdata0 = 8'h10; rw0 = 1'b0;
        wait_start(1'b1);
        tick(19);
        check("t_no_early_ack", 32'(t_ack0), 32'd0);
        tick(1);
        check("t_ack0", 32'(t_ack0), 32'd1);
        check("t_err0", 32'(t_err0), 32'd1);
        check("t_rdata", 32'(t_rdata), 32'd0);
        check("t_ack1_err1", 32'({t_ack1, t_err1}), 32'd0);
        check("t_fields", 32'({t_grant, t_slave_add, t_data, t_r_w}),
              32'({2'b01, 7'h2A, 8'h10, 1'b0}));
        req0 = 1'b0;
        tick(2);
        req1 = 1'b1; add1 = 7'h33; rw1 = 1'b1;
        serve(1'b1, 1, 3, 1'b0, 8'h66);
        check("t_next_ack1", 32'(t_ack1), 32'd1);
        check("t_next_err1", 32'(t_err1), 32'd0);
        check("t_next_rdata", 32'(t_rdata), 32'h66);
        req1 = 1'b0; rw1 = 1'b0;

        // Reset during WAIT_DONE.
        do_reset();
        req1 = 1'b1; add1 = 7'h4B; wdata1 = 8'hC3; rw1 = 1'b0;
        wait_start(1'b0);
        m_busy = 1'b1;
        tick(3);
        a1 = ack1_cnt;
        #2;
        rst_n = 1'b0;
        req0 = 1'b1; add0 = 7'h12; wdata0 = 8'h34; rw0 = 1'b0;
        #1;
        check("m_rst_grant", 32'(grant), 32'd0);
        check("m_rst_start", 32'(m_start_cond), 32'd0);
        check("m_rst_fields", 32'({m_slave_add, m_data, m_r_w, rdata}), 32'd0);
        check("m_rst_acks", 32'({ack0, ack1, err0, err1}), 32'd0);
        m_busy = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("m_tie_grant", 32'(grant), 32'b01);
        check("m_tie_add", 32'(m_slave_add), 32'h12);
        check("m_no_abort_ack", 32'(ack1_cnt), 32'(a1));
        serve(1'b0, 1, 3, 1'b0, 8'h00);
        check("m_ack0", 32'(ack0), 32'd1);
        req0 = 1'b0;
        serve(1'b0, 1, 3, 1'b0, 8'h00);
        check("m_ack1", 32'(ack1), 32'd1);
        check("m_grant1", 32'(grant), 32'b10);
        req1 = 1'b0;

        // Request dropped during START.
        tick(2);
        req0 = 1'b1; add0 = 7'h05; wdata0 = 8'h77; rw0 = 1'b0;
        tick(3);
        check("d_in_start", 32'(m_start_cond), 32'd1);
        req0 = 1'b0;
        serve(1'b0, 1, 4, 1'b0, 8'h00);
        check("d_ack0", 32'(ack0), 32'd1);
        check("d_err0", 32'(err0), 32'd0);
        tick(1);
        check("d_grant_idle", 32'(grant), 32'd0);
        tick(3);
        check("d_stay_idle", 32'({grant, m_start_cond}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
